// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory port between the D-cache, I-cache and page-table walker.
// One transaction at a time: grant in IDLE, wait for mem_ready (or time out) in BUSY, pulse ready in RESP.
module mem_rr_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  // D-cache port
  input  logic         d_req,
  input  logic         d_we,
  input  logic [31:0]  d_addr,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_ready,
  output logic         d_err,
  // I-cache port
  input  logic         i_req,
  input  logic         i_we,
  input  logic [31:0]  i_addr,
  input  logic [127:0] i_wdata,
  output logic [127:0] i_rdata,
  output logic         i_ready,
  output logic         i_err,
  // page-table-walker port (read-only)
  input  logic         p_req,
  input  logic [31:0]  p_addr,
  output logic [127:0] p_rdata,
  output logic         p_ready,
  output logic         p_err,
  // shared memory
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  // status
  output logic         busy,
  output logic [1:0]   grant_id
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e         state_q;
  logic [1:0]     last_grant_q;
  logic           we_q;
  logic [31:0]    addr_q;
  logic [127:0]   wdata_q;
  logic [127:0]   rdata_q;
  logic           err_q;
  logic [CW-1:0]  cnt_q;
  logic           mem_req_q;
  logic           busy_q;
  logic [2:0]     ready_q;

  logic [2:0]     req_vec;
  logic [1:0]     cand1, cand2;
  logic [1:0]     winner_d;
  logic           any_req;
  logic           win_we_d;
  logic [31:0]    win_addr_d;
  logic [127:0]   win_wdata_d;

  function automatic logic [1:0] rr_next(input logic [1:0] g);
    case (g)
      2'd0:    rr_next = 2'd1;
      2'd1:    rr_next = 2'd2;
      default: rr_next = 2'd0;
    endcase
  endfunction

  assign req_vec = {p_req, i_req, d_req};
  assign any_req = |req_vec;
  assign cand1   = rr_next(last_grant_q);
  assign cand2   = rr_next(cand1);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    winner_d    = last_grant_q;
    win_we_d    = 1'b0;
    win_addr_d  = p_addr;
    win_wdata_d = '0;
    if (req_vec[cand1])             winner_d = cand1;
    else if (req_vec[cand2])        winner_d = cand2;
    else if (req_vec[last_grant_q]) winner_d = last_grant_q;
    case (winner_d)
      2'd0: begin
        win_we_d    = d_we;
        win_addr_d  = d_addr;
        win_wdata_d = d_wdata;
      end
      2'd1: begin
        win_we_d    = i_we;
        win_addr_d  = i_addr;
        win_wdata_d = i_wdata;
      end
      default: ;  // walker is read-only: we=0, wdata=0
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 2'd2;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          ready_q <= '0;
          if (any_req) begin
            last_grant_q <= winner_d;
            we_q         <= win_we_d;
            addr_q       <= win_addr_d;
            wdata_q      <= win_wdata_d;
            cnt_q        <= CW'(1);
            mem_req_q    <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_BUSY;
          end
        end
        S_BUSY: begin
          // a late mem_ready on the final cycle still wins over the timeout
          if (mem_ready) begin
            rdata_q   <= mem_rdata;
            err_q     <= 1'b0;
            mem_req_q <= 1'b0;
            ready_q   <= 3'b001 << last_grant_q;
            state_q   <= S_RESP;
          end else if (cnt_q == TIMEOUT_C) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
            mem_req_q <= 1'b0;
            ready_q   <= 3'b001 << last_grant_q;
            state_q   <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          ready_q <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q   <= '0;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign d_rdata = rdata_q;
  assign i_rdata = rdata_q;
  assign p_rdata = rdata_q;

  assign d_ready = ready_q[0];
  assign i_ready = ready_q[1];
  assign p_ready = ready_q[2];
  assign d_err   = ready_q[0] & err_q;
  assign i_err   = ready_q[1] & err_q;
  assign p_err   = ready_q[2] & err_q;

  assign busy     = busy_q;
  assign grant_id = last_grant_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_mem_rr_arbiter;

  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         d_req, d_we, i_req, i_we, p_req;
  logic [31:0]  d_addr, i_addr, p_addr;
  logic [127:0] d_wdata, i_wdata;
  logic [127:0] d_rdata, i_rdata, p_rdata;
  logic         d_ready, d_err, i_ready, i_err, p_ready, p_err;
  logic         mem_req, mem_we, mem_ready;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         busy;
  logic [1:0]   grant_id;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // requester-side model state for the randomized test
  logic         pend[3];
  logic         we_m[3];
  logic [31:0]  addr_m[3];
  logic [127:0] wd_m[3];

  mem_rr_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready), .i_err(i_err),
    .p_req(p_req), .p_addr(p_addr),
    .p_rdata(p_rdata), .p_ready(p_ready), .p_err(p_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
    p_req = 0; p_addr = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic drive_ports;
    d_req = pend[0]; d_we = we_m[0]; d_addr = addr_m[0]; d_wdata = wd_m[0];
    i_req = pend[1]; i_we = we_m[1]; i_addr = addr_m[1]; i_wdata = wd_m[1];
    p_req = pend[2]; p_addr = addr_m[2];
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    d_req = 1; i_req = 1; p_req = 1; mem_ready = 1; mem_rdata = {4{32'hDEADBEEF}};
    tick();
    tick();
    checks++;
    if ({mem_req, busy, d_ready, i_ready, p_ready, d_err, i_err, p_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {mem_req, busy, d_ready, i_ready, p_ready, d_err, i_err, p_err});
    end
    checks++;
    if (grant_id !== 2'd2) begin
      errors++; $display("FAIL reset_grant_id: got %0d expected 2", grant_id);
    end
    checks++;
    if (d_rdata !== '0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", d_rdata);
    end
    clear_inputs();
    rst = 0;
    tick();
  endtask

  task automatic test_single_read;
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h0000_1000;
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr, grant_id} !== {1'b1, 1'b0, 32'h0000_1000, 2'd0}) begin
      errors++;
      $display("FAIL single_busy: got req=%b we=%b addr=%h gid=%0d expected req=1 we=0 addr=00001000 gid=0",
               mem_req, mem_we, mem_addr, grant_id);
    end
    tick();
    tick();
    mem_ready = 1; mem_rdata = a5;
    tick();
    checks++;
    if ({d_ready, d_err, i_ready, p_ready, busy, mem_req} !== 6'b100010) begin
      errors++;
      $display("FAIL single_resp_flags: got %b expected 100010",
               {d_ready, d_err, i_ready, p_ready, busy, mem_req});
    end
    checks++;
    if (d_rdata !== a5) begin
      errors++; $display("FAIL single_rdata: got %h expected %h", d_rdata, a5);
    end
    d_req = 0; mem_ready = 0; mem_rdata = '0;
    tick();
    checks++;
    if ({d_ready, busy, mem_req} !== 3'b000 || d_rdata !== a5) begin
      errors++;
      $display("FAIL single_idle: got ready=%b busy=%b req=%b rdata=%h expected 0 0 0 %h",
               d_ready, busy, mem_req, d_rdata, a5);
    end
  endtask

  task automatic test_contention;
    int           seq[4];
    logic [31:0]  adr[3];
    logic [2:0]   oh;
    seq = '{0, 1, 2, 0};
    adr = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300};
    do_reset();
    d_req = 1; i_req = 1; p_req = 1;
    d_addr = adr[0]; i_addr = adr[1]; p_addr = adr[2];
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (grant_id !== 2'(seq[n]) || mem_addr !== adr[seq[n]]) begin
        errors++;
        $display("FAIL contention_grant%0d: got gid=%0d addr=%h expected gid=%0d addr=%h",
                 n, grant_id, mem_addr, seq[n], adr[seq[n]]);
      end
      mem_ready = 1;
      tick();
      oh = 3'b001 << seq[n];
      checks++;
      if ({p_ready, i_ready, d_ready} !== oh) begin
        errors++;
        $display("FAIL contention_ready%0d: got %b expected %b", n, {p_ready, i_ready, d_ready}, oh);
      end
      mem_ready = 0;
      tick();
    end
  endtask

  task automatic test_operand_stability;
    logic [127:0] w1;
    w1 = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    do_reset();
    d_req = 1; d_we = 1; d_addr = 32'h0000_1000; d_wdata = w1;
    tick();
    d_addr = 32'h0000_2000; d_we = 0; d_wdata = ~w1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h0000_1000, w1}) begin
        errors++;
        $display("FAIL stability_busy%0d: got req=%b we=%b addr=%h wdata=%h expected 1 1 00001000 %h",
                 c, mem_req, mem_we, mem_addr, mem_wdata, w1);
      end
      if (c == 3) mem_ready = 1;
      tick();
    end
    checks++;
    if ({d_ready, mem_req} !== 2'b10) begin
      errors++; $display("FAIL stability_resp: got ready,req=%b expected 10", {d_ready, mem_req});
    end
    d_req = 0; mem_ready = 0;
    tick();
  endtask

  task automatic test_timeout;
    int n;
    do_reset();
    p_req = 1; p_addr = 32'h00AB_C000;
    tick();
    mem_ready = 1; mem_rdata = '1;
    tick();
    checks++;
    if ({p_ready, p_err} !== 2'b10 || p_rdata !== '1) begin
      errors++;
      $display("FAIL timeout_preload: got ready=%b err=%b rdata=%h expected 1 0 all-ones", p_ready, p_err, p_rdata);
    end
    p_req = 0; mem_ready = 0;
    tick();
    p_req = 1; p_addr = 32'h00DE_F000;
    d_we = 1; d_wdata = {4{32'hCAFE_F00D}};
    tick();
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_req !== 1'b1) break;
      n++;
      checks++;
      if ({mem_we, mem_wdata, mem_addr, grant_id} !== {1'b0, 128'h0, 32'h00DE_F000, 2'd2}) begin
        errors++;
        $display("FAIL timeout_operands%0d: got we=%b wdata=%h addr=%h gid=%0d expected 0 0 00def000 2",
                 c, mem_we, mem_wdata, mem_addr, grant_id);
      end
      tick();
    end
    checks++;
    if (n != TO) begin
      errors++; $display("FAIL timeout_req_cycles: got %0d expected %0d", n, TO);
    end
    checks++;
    if ({p_ready, p_err, d_ready, i_ready, d_err, i_err, busy} !== 7'b1100001 || p_rdata !== '0) begin
      errors++;
      $display("FAIL timeout_resp: got flags=%b rdata=%h expected 1100001 0",
               {p_ready, p_err, d_ready, i_ready, d_err, i_err, busy}, p_rdata);
    end
    p_req = 0; mem_ready = 1; mem_rdata = '1;
    tick();
    checks++;
    if ({busy, p_ready, p_err, mem_req} !== 4'b0000) begin
      errors++; $display("FAIL timeout_idle: got %b expected 0000", {busy, p_ready, p_err, mem_req});
    end
    tick();
    checks++;
    if (busy !== 1'b0 || p_rdata !== '0) begin
      errors++; $display("FAIL idle_ignores_ready: got busy=%b rdata=%h expected 0 0", busy, p_rdata);
    end
    mem_ready = 0;
  endtask

  task automatic test_reset_mid_busy;
    do_reset();
    i_req = 1; i_addr = 32'h0000_4000;
    d_addr = 32'h0000_5000;
    tick();
    checks++;
    if ({mem_req, grant_id} !== {1'b1, 2'd1}) begin
      errors++; $display("FAIL midrst_first_grant: got req=%b gid=%0d expected 1 1", mem_req, grant_id);
    end
    tick();
    rst = 1; d_req = 1;
    tick();
    rst = 0;
    checks++;
    if ({mem_req, busy, d_ready, i_ready, p_ready} !== 5'b00000 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL midrst_abort: got flags=%b gid=%0d expected 00000 2",
               {mem_req, busy, d_ready, i_ready, p_ready}, grant_id);
    end
    tick();
    checks++;
    if ({mem_req, grant_id, mem_addr, d_ready, i_ready} !== {1'b1, 2'd0, 32'h0000_5000, 2'b00}) begin
      errors++;
      $display("FAIL midrst_regrant: got req=%b gid=%0d addr=%h rdy=%b%b expected 1 0 00005000 00",
               mem_req, grant_id, mem_addr, d_ready, i_ready);
    end
    mem_ready = 1;
    tick();
    checks++;
    if ({p_ready, i_ready, d_ready} !== 3'b001) begin
      errors++; $display("FAIL midrst_resp: got %b expected 001", {p_ready, i_ready, d_ready});
    end
    do_reset();
  endtask

  task automatic test_back_to_back;
    int t0, prev, cnt;
    do_reset();
    i_req = 1; i_addr = 32'h0000_8000;
    t0 = cyc; prev = -1; cnt = 0;
    for (int k = 0; k < 15; k++) begin
      mem_ready = mem_req;
      tick();
      if (i_ready === 1'b1) begin
        cnt++;
        checks++;
        if (prev < 0) begin
          if (cyc - t0 != 2) begin
            errors++; $display("FAIL b2b_first_latency: got %0d expected 2", cyc - t0);
          end
        end else if (cyc - prev != 3) begin
          errors++; $display("FAIL b2b_period: got %0d expected 3", cyc - prev);
        end
        prev = cyc;
      end
    end
    checks++;
    if (cnt != 5) begin
      errors++; $display("FAIL b2b_count: got %0d expected 5", cnt);
    end
    do_reset();
  endtask

  task automatic test_random;
    int           last, w, lat, pf;
    logic         exp_err;
    logic         exp_we;
    logic [127:0] exp_data, exp_wd, rd;
    logic [2:0]   oh, ev;
    do_reset();
    last = 2;
    for (int p = 0; p < 3; p++) begin
      pend[p] = 0; we_m[p] = 0; addr_m[p] = '0; wd_m[p] = '0;
    end
    for (int n = 0; n < 40; n++) begin
      pf = $urandom_range(2, 0);
      for (int p = 0; p < 3; p++) begin
        if (!pend[p] && ($urandom_range(1, 0) == 1 || p == pf)) begin
          pend[p]   = 1;
          addr_m[p] = $urandom;
          we_m[p]   = (p == 2) ? 1'b0 : 1'($urandom_range(1, 0));
          wd_m[p]   = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      drive_ports();
      mem_ready = 1'($urandom_range(1, 0));
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      w = -1;
      for (int k = 1; k <= 3; k++)
        if (w < 0 && pend[(last + k) % 3]) w = (last + k) % 3;
      last = w;
      exp_we = (w == 2) ? 1'b0 : we_m[w];
      exp_wd = (w == 2) ? 128'h0 : wd_m[w];
      oh     = 3'b001 << w;
      tick();
      lat      = $urandom_range(TO + 3, 1);
      exp_err  = (lat > TO);
      exp_data = '0;
      for (int c = 1; c <= TO; c++) begin
        checks++;
        if ({mem_req, busy, mem_we, mem_addr, mem_wdata, grant_id, p_ready, i_ready, d_ready} !==
            {1'b1, 1'b1, exp_we, addr_m[w], exp_wd, 2'(w), 3'b000}) begin
          errors++;
          $display("FAIL rand_busy t%0d c%0d: got req=%b busy=%b we=%b addr=%h wd=%h gid=%0d rdy=%b expected 1 1 %b %h %h %0d 000",
                   n, c, mem_req, busy, mem_we, mem_addr, mem_wdata, grant_id,
                   {p_ready, i_ready, d_ready}, exp_we, addr_m[w], exp_wd, w);
        end
        rd = {$urandom, $urandom, $urandom, $urandom};
        mem_rdata = rd;
        mem_ready = (c == lat);
        if (c == lat) exp_data = rd;
        tick();
        if (c == lat) break;
      end
      ev = exp_err ? oh : 3'b000;
      checks++;
      if ({p_ready, i_ready, d_ready, p_err, i_err, d_err, grant_id, busy, mem_req} !==
          {oh, ev, 2'(w), 1'b1, 1'b0} ||
          {d_rdata, i_rdata, p_rdata} !== {3{exp_data}}) begin
        errors++;
        $display("FAIL rand_resp t%0d: got rdy=%b err=%b gid=%0d busy=%b req=%b rdata=%h expected %b %b %0d 1 0 %h",
                 n, {p_ready, i_ready, d_ready}, {p_err, i_err, d_err}, grant_id, busy, mem_req,
                 d_rdata, oh, ev, w, exp_data);
      end
      pend[w] = 0;
      drive_ports();
      mem_ready = 1'($urandom_range(1, 0));
      tick();
      checks++;
      if ({busy, mem_req, p_ready, i_ready, d_ready, p_err, i_err, d_err} !== 8'h00) begin
        errors++;
        $display("FAIL rand_idle t%0d: got %b expected 00000000",
                 n, {busy, mem_req, p_ready, i_ready, d_ready, p_err, i_err, d_err});
      end
    end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_operand_stability();
    test_timeout();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: maximum BUSY cycles to wait for mem_ready before aborting.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports d_req/d_we, input, 1 each: D-cache request and write enable.
REQ-005 SHALL have ports d_addr (32) and d_wdata (128), input: D-cache line address and write data.
REQ-006 SHALL have ports d_rdata (128) and d_ready/d_err (1 each), output: D-cache response data, done pulse and error flag.
REQ-007 SHALL have ports i_req, i_we, i_addr[31:0], i_wdata[127:0], i_rdata[127:0], i_ready, i_err: the I-cache port, same directions and meaning as the D port.
REQ-008 SHALL have ports p_req (in, 1), p_addr (in, 32), p_rdata (out, 128), p_ready (out, 1), p_err (out, 1): the TLB page-table-walker port, read-only.
REQ-009 SHALL have ports mem_req/mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 128): the shared memory request.
REQ-010 SHALL have ports mem_rdata (in, 128) and mem_ready (in, 1): the memory response.
REQ-011 SHALL have ports busy (out, 1) and grant_id (out, 2): busy is high while a transaction is active; grant_id is the current or last grantee (0=D, 1=I, 2=P).

Function
REQ-012 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; no other states or transitions.
REQ-013 SHALL, in IDLE with any req high, pick one winner by round-robin: search order begins at port (last_grant+1) mod 3, over 0=D, 1=I, 2=P.
REQ-014 SHALL, on the IDLE grant edge, latch the winner's we, addr and wdata (we=0 and wdata=0 for P), update last_grant and grant_id, and enter BUSY.
REQ-015 SHALL drive mem_req=1 only in BUSY, with mem_we/mem_addr/mem_wdata taken from the latched registers only; requester-side input changes after the grant have no effect.
REQ-016 SHALL, in BUSY with mem_ready=1, capture mem_rdata into a 128-bit response register, clear the error flag and enter RESP.
REQ-017 SHALL count BUSY cycles from 1. When the count reaches TIMEOUT with mem_ready still low, SHALL enter RESP with error flag=1 and response register=0, and drop mem_req.
REQ-018 SHALL, in RESP, assert ready of the granted port only, for exactly one cycle, with err of that port equal to the error flag; the other ports' ready and err stay 0.
REQ-019 SHALL drive d_rdata, i_rdata and p_rdata from the response register in all states; the value is held until the next capture and is valid only while the port's ready is high.
REQ-020 SHALL ignore mem_ready in IDLE and RESP.
REQ-021 SHALL require each requester to hold req and its operands stable until it samples ready=1, and to deassert req the following cycle. A req still high in IDLE is treated as a new request.
REQ-022 SHALL have this latency: req first high in IDLE cycle t gives mem_req high at t+1. mem_ready at cycle m gives ready at m+1 and IDLE at m+2. Minimum request-to-ready is 2 cycles.
REQ-023 SHALL set busy=1 in BUSY and RESP and busy=0 in IDLE.
REQ-024 SHALL, with all three req high continuously, grant D, I, P, D, ... in strict rotation; no port waits more than two other transactions.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, set state=IDLE, last_grant=2, grant_id=2, timeout counter=0, response register=0 and error flag=0.
REQ-026 SHALL drive these outputs after reset: mem_req=0, all ready=0, all err=0, busy=0.
REQ-027 SHALL apply reset asserted in BUSY or RESP immediately: mem_req low the next cycle and no ready pulse issued for the aborted transaction.
REQ-028 SHALL grant D first after reset when D, I and P all request together.

Verification
REQ-029 Single D read: d_req=1, d_addr=0x1000, mem_ready at the 3rd BUSY cycle with mem_rdata=0xA5..A5 -> one-cycle d_ready, d_rdata=0xA5..A5, d_err=0, i_ready=p_ready=0.
REQ-030 Three-way contention after reset, all req held -> grant_id sequence 0,1,2,0; each port gets exactly one ready per transaction.
REQ-031 Operand stability: change d_addr 0x1000 -> 0x2000 during BUSY -> mem_addr stays 0x1000 until RESP.
REQ-032 Timeout with TIMEOUT=8 and mem_ready never high -> mem_req high for exactly 8 cycles, then p_ready=1, p_err=1, p_rdata=0, then IDLE.
REQ-033 Reset mid-BUSY: rst=1 for one cycle during BUSY -> mem_req=0 and busy=0 next cycle, no ready pulse, next grant goes to D.
REQ-034 Back-to-back single requester: i_req reasserted right after i_ready, zero-wait memory (mem_ready high during the first BUSY cycle) -> one transaction every 3 cycles.
